// File: rtl/reg_exchange_bank_pkg.sv
// Shared mode encodings and channel-slice helper for the register exchange bank.
package reg_exchange_pkg;

   localparam logic [2:0] MODE_HOLD  = 3'd0;
   localparam logic [2:0] MODE_ROTL  = 3'd1;
   localparam logic [2:0] MODE_ROTR  = 3'd2;
   localparam logic [2:0] MODE_PSWAP = 3'd3;
   localparam logic [2:0] MODE_REV   = 3'd4;

   localparam int unsigned CH_W = 4;

   // LSB position of channel ch inside the flattened bank vector.
   function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
      return ch * width;
   endfunction

endpackage

// File: rtl/reg_exchange_bank_delay.sv
// Fixed-latency write pipe: a write issued at edge k is presented for landing
// during the cycle before edge k+WR_DELAY.
module write_delay_line #(
   parameter int WR_DELAY = 2,
   parameter int CH_W     = 4,
   parameter int WIDTH    = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [CH_W-1:0]  in_ch,
   input  logic [WIDTH-1:0] in_data,
   output logic             land_valid,
   output logic [CH_W-1:0]  land_ch,
   output logic [WIDTH-1:0] land_data,
   output logic             busy
);

   logic [WR_DELAY-1:0] vld_q;
   logic [CH_W-1:0]     ch_q   [WR_DELAY];
   logic [WIDTH-1:0]    data_q [WR_DELAY];

   // Shift stage 0 toward the landing stage; reset flushes anything in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         for (int i = 0; i < WR_DELAY; i++) begin
            ch_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         vld_q[0]  <= in_valid;
         ch_q[0]   <= in_ch;
         data_q[0] <= in_data;
         for (int i = 1; i < WR_DELAY; i++) begin
            vld_q[i]  <= vld_q[i-1];
            ch_q[i]   <= ch_q[i-1];
            data_q[i] <= data_q[i-1];
         end
      end
   end

   assign land_valid = vld_q[WR_DELAY-1];
   assign land_ch    = ch_q[WR_DELAY-1];
   assign land_data  = data_q[WR_DELAY-1];
   assign busy       = |vld_q;

endmodule

// File: rtl/reg_exchange_bank.sv
// Bank of CHANNELS registers permuted on command, with delayed logical-index writes
// that override the permutation result on the landing edge.
module reg_exchange_bank
   import reg_exchange_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter int               CHANNELS = 4,
   parameter int               WR_DELAY = 2,
   parameter logic [WIDTH-1:0] INIT     = '0
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      op_valid,
   input  logic [2:0]                mode,
   input  logic                      wr_valid,
   input  logic [3:0]                wr_ch,
   input  logic [WIDTH-1:0]          wr_data,
   output logic [CHANNELS*WIDTH-1:0] q,
   output logic                      busy,
   output logic [7:0]                op_count,
   output logic                      err
);

   logic [WIDTH-1:0] bank_q [CHANNELS];
   logic [WIDTH-1:0] bank_d [CHANNELS];
   logic [WIDTH-1:0] perm_s [CHANNELS];
   logic [7:0]       op_count_q;
   logic [7:0]       op_count_d;
   logic             err_q;
   logic             err_d;
   logic             wr_ok_s;
   logic             wr_bad_s;
   logic             mode_bad_s;
   logic             count_s;
   logic             land_valid_s;
   logic [CH_W-1:0]  land_ch_s;
   logic [WIDTH-1:0] land_data_s;

   assign wr_ok_s    = wr_valid && ({1'b0, wr_ch} <  5'(CHANNELS));
   assign wr_bad_s   = wr_valid && ({1'b0, wr_ch} >= 5'(CHANNELS));
   assign mode_bad_s = op_valid && (mode > MODE_REV);
   assign count_s    = op_valid && (mode != MODE_HOLD) && (mode <= MODE_REV);

   write_delay_line #(
      .WR_DELAY (WR_DELAY),
      .CH_W     (CH_W),
      .WIDTH    (WIDTH)
   ) u_delay (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (wr_ok_s),
      .in_ch      (wr_ch),
      .in_data    (wr_data),
      .land_valid (land_valid_s),
      .land_ch    (land_ch_s),
      .land_data  (land_data_s),
      .busy       (busy)
   );

   // Permutation from pre-edge contents only; reserved modes fall through to hold.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         perm_s[i] = bank_q[i];
      end
      if (op_valid) begin
         case (mode)
            MODE_ROTL: begin
               for (int i = 0; i < CHANNELS; i++) perm_s[i] = bank_q[(i + 1) % CHANNELS];
            end
            MODE_ROTR: begin
               for (int i = 0; i < CHANNELS; i++) perm_s[i] = bank_q[(i + CHANNELS - 1) % CHANNELS];
            end
            MODE_PSWAP: begin
               for (int i = 0; i < CHANNELS; i++) begin
                  if ((i ^ 1) < CHANNELS) perm_s[i] = bank_q[i ^ 1];
                  else                    perm_s[i] = bank_q[i];
               end
            end
            MODE_REV: begin
               for (int i = 0; i < CHANNELS; i++) perm_s[i] = bank_q[CHANNELS - 1 - i];
            end
            default: begin
               for (int i = 0; i < CHANNELS; i++) perm_s[i] = bank_q[i];
            end
         endcase
      end else begin
         for (int i = 0; i < CHANNELS; i++) perm_s[i] = bank_q[i];
      end
   end

   // Landing write targets the logical channel after permutation, so it wins.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (land_valid_s && (land_ch_s == CH_W'(i))) bank_d[i] = land_data_s;
         else                                         bank_d[i] = perm_s[i];
      end
      op_count_d = count_s ? (op_count_q + 8'd1) : op_count_q;
      err_d      = mode_bad_s || wr_bad_s;
   end

   // Bank, op counter and error pulse registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) bank_q[i] <= INIT;
         op_count_q <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) bank_q[i] <= bank_d[i];
         op_count_q <= op_count_d;
         err_q      <= err_d;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
      assign q[ch_lsb(g, WIDTH) +: WIDTH] = bank_q[g];
   end

   assign op_count = op_count_q;
   assign err      = err_q;

endmodule
